// File: rtl/vector_sequencer.sv
// Vector sequencer: stores stimulus vectors, replays them to two DUT
// implementations with a programmable hold time, and counts result mismatches.
module vector_sequencer #(
   parameter int VEC_W = 64,
   parameter int OUT_W = 32,
   parameter int DEPTH = 16,
   parameter int HOLD  = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_valid,
   input  logic [VEC_W-1:0]           load_data,
   output logic                       load_ready,
   input  logic                       clr,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [VEC_W-1:0]           vec_out,
   output logic                       vec_valid,
   input  logic [OUT_W-1:0]           dut_y_a,
   input  logic [OUT_W-1:0]           dut_y_b,
   output logic [15:0]                mismatch_cnt,
   output logic [$clog2(DEPTH)-1:0]   first_bad_idx,
   output logic                       mismatch_seen
);

   localparam int AW = $clog2(DEPTH);
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
   localparam logic [AW-1:0] IDX0      = '0;

   typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

   state_t             state;
   logic [AW:0]        count;
   logic [AW-1:0]      idx;
   logic [AW-1:0]      idx_nxt;
   logic [HW-1:0]      hold;
   logic               busy_r;
   logic               done_r;
   logic [VEC_W-1:0]   vec_p0;
   logic               vld_p0;
   logic               load_acc;
   logic               last_vec;
   logic               hold_end;
   logic [VEC_W-1:0]   mem [DEPTH];

   // Saturating increment for the mismatch counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign load_ready = (state == IDLE) && (count < DEPTH_C) && !start;
   assign load_acc   = load_valid && load_ready && !clr;
   assign idx_nxt    = idx + 1'b1;
   assign last_vec   = ({1'b0, idx} == (count - 1'b1));
   assign hold_end   = (hold == HOLD_LAST);

   assign busy      = busy_r;
   assign done      = done_r;
   assign vec_out   = vec_p0;
   assign vec_valid = vld_p0;

   // Vector storage: append at the current fill level, contents survive runs.
   always_ff @(posedge clk) begin
      if (load_acc)
         mem[count[AW-1:0]] <= load_data;
   end

   // Control FSM with registered stimulus and compare bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         count         <= '0;
         idx           <= '0;
         hold          <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         vec_p0        <= '0;
         vld_p0        <= 1'b0;
         mismatch_cnt  <= '0;
         first_bad_idx <= '0;
         mismatch_seen <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (start && (count != '0)) begin
                  state         <= APPLY;
                  busy_r        <= 1'b1;
                  idx           <= '0;
                  hold          <= '0;
                  vec_p0        <= mem[IDX0];
                  vld_p0        <= 1'b1;
                  mismatch_cnt  <= '0;
                  first_bad_idx <= '0;
                  mismatch_seen <= 1'b0;
               end else if (clr) begin
                  count <= '0;
               end else if (load_acc) begin
                  count <= count + 1'b1;
               end
            end
            // Stage p0 boundary: vec_p0/vld_p0 drive the DUTs; results compared at end of hold.
            APPLY: begin
               if (hold_end) begin
                  if (dut_y_a != dut_y_b) begin
                     mismatch_cnt <= sat_inc16(mismatch_cnt);
                     if (!mismatch_seen) begin
                        mismatch_seen <= 1'b1;
                        first_bad_idx <= idx;
                     end
                  end
                  if (last_vec) begin
                     state  <= DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     vec_p0 <= '0;
                     vld_p0 <= 1'b0;
                  end else begin
                     idx    <= idx_nxt;
                     hold   <= '0;
                     vec_p0 <= mem[idx_nxt];
                  end
               end else begin
                  hold <= hold + 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_r <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
               vec_p0 <= '0;
               vld_p0 <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer with default parameters (HOLD=2, DEPTH=16).
module tb_vector_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_valid;
   logic [63:0] load_data;
   logic        load_ready;
   logic        clr;
   logic        start;
   logic        busy;
   logic        done;
   logic [63:0] vec_out;
   logic        vec_valid;
   logic [31:0] dut_y_a;
   logic [31:0] dut_y_b;
   logic [15:0] mismatch_cnt;
   logic [3:0]  first_bad_idx;
   logic        mismatch_seen;

   int bad_mode;   // 0: results match, 1: flip while vec_out=='h22, 2: always flip
   int errors;
   int checks;

   typedef struct {
      logic [63:0] vec;
      logic        valid;
      logic        busy;
      logic        done;
   } cyc_t;

   cyc_t run3 [8];
   cyc_t tbl [$];

   vector_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .clr(clr), .start(start), .busy(busy), .done(done),
      .vec_out(vec_out), .vec_valid(vec_valid),
      .dut_y_a(dut_y_a), .dut_y_b(dut_y_b),
      .mismatch_cnt(mismatch_cnt), .first_bad_idx(first_bad_idx),
      .mismatch_seen(mismatch_seen)
   );

   always #5 clk = ~clk;

   assign dut_y_a = vec_out[31:0] + 32'h5;
   assign dut_y_b = dut_y_a ^ {31'b0, (bad_mode == 2) || ((bad_mode == 1) && (vec_out == 64'h22))};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [63:0] v);
      load_valid = 1'b1;
      load_data  = v;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Walk the expected-cycle table starting in the cycle after start.
   task automatic apply_table(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         check($sformatf("%s c%0d vec_out", tag, i + 1), vec_out, tbl[i].vec);
         check($sformatf("%s c%0d vec_valid", tag, i + 1), {63'b0, vec_valid}, {63'b0, tbl[i].valid});
         check($sformatf("%s c%0d busy", tag, i + 1), {63'b0, busy}, {63'b0, tbl[i].busy});
         check($sformatf("%s c%0d done", tag, i + 1), {63'b0, done}, {63'b0, tbl[i].done});
         @(posedge clk);
         #1;
      end
   endtask

   task automatic use_run3();
      tbl.delete();
      for (int i = 0; i < 8; i++) tbl.push_back(run3[i]);
   endtask

   // Builds the expected table for n stored vectors starting at base, step 1, HOLD=2.
   task automatic build_run(input logic [63:0] base, input int n);
      cyc_t r;
      tbl.delete();
      for (int c = 0; c < 2 * n; c++) begin
         r.vec = base + 64'(c / 2); r.valid = 1'b1; r.busy = 1'b1; r.done = 1'b0;
         tbl.push_back(r);
      end
      r.vec = '0; r.valid = 1'b0; r.busy = 1'b0; r.done = 1'b1;
      tbl.push_back(r);
      r.done = 1'b0;
      tbl.push_back(r);
   endtask

   initial begin
      run3[0] = '{64'h11, 1'b1, 1'b1, 1'b0};
      run3[1] = '{64'h11, 1'b1, 1'b1, 1'b0};
      run3[2] = '{64'h22, 1'b1, 1'b1, 1'b0};
      run3[3] = '{64'h22, 1'b1, 1'b1, 1'b0};
      run3[4] = '{64'h33, 1'b1, 1'b1, 1'b0};
      run3[5] = '{64'h33, 1'b1, 1'b1, 1'b0};
      run3[6] = '{64'h00, 1'b0, 1'b0, 1'b1};
      run3[7] = '{64'h00, 1'b0, 1'b0, 1'b0};

      errors = 0; checks = 0; bad_mode = 0;
      rst_n = 1'b0; load_valid = 1'b0; load_data = '0; clr = 1'b0; start = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst load_ready", {63'b0, load_ready}, 64'd1);
      check("rst outputs", {busy, done, vec_valid, mismatch_seen}, 64'd0);
      check("rst vec_out", vec_out, 64'd0);
      check("rst mismatch_cnt", {48'b0, mismatch_cnt}, 64'd0);
      check("rst first_bad_idx", {60'b0, first_bad_idx}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Three matching vectors
      load(64'h11); load(64'h22); load(64'h33);
      pulse_start();
      use_run3();
      apply_table("match");
      check("match mismatch_cnt", {48'b0, mismatch_cnt}, 64'd0);
      check("match mismatch_seen", {63'b0, mismatch_seen}, 64'd0);

      // Mismatch only on the second vector
      bad_mode = 1;
      pulse_start();
      apply_table("bad22");
      check("bad22 mismatch_cnt", {48'b0, mismatch_cnt}, 64'd1);
      check("bad22 first_bad_idx", {60'b0, first_bad_idx}, 64'd1);
      check("bad22 mismatch_seen", {63'b0, mismatch_seen}, 64'd1);

      // Replay with matching results clears the mismatch record
      bad_mode = 0;
      pulse_start();
      apply_table("replay");
      check("replay mismatch_cnt", {48'b0, mismatch_cnt}, 64'd0);
      check("replay first_bad_idx", {60'b0, first_bad_idx}, 64'd0);
      check("replay mismatch_seen", {63'b0, mismatch_seen}, 64'd0);

      // Empty memory: start is ignored
      do_clr();
      start = 1'b1;
      #1;
      check("start masks load_ready", {63'b0, load_ready}, 64'd0);
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("empty c%0d busy/done/valid", i), {61'b0, busy, done, vec_valid}, 64'd0);
      end
      tick();

      // start together with load_valid at count=2: load is dropped
      load(64'hA1); load(64'hA2);
      start = 1'b1; load_valid = 1'b1; load_data = 64'hEE;
      tick();
      start = 1'b0; load_valid = 1'b0;
      build_run(64'hA1, 2);
      apply_table("startload");

      // Fill to DEPTH, overflow attempt, then full replay
      do_clr();
      for (int i = 0; i < 16; i++) load(64'h100 + 64'(i));
      @(negedge clk);
      check("full load_ready", {63'b0, load_ready}, 64'd0);
      tick();
      load(64'hDEAD);
      pulse_start();
      build_run(64'h100, 16);
      apply_table("full");
      do_clr();
      @(negedge clk);
      check("clr load_ready", {63'b0, load_ready}, 64'd1);
      tick();
      pulse_start();
      @(negedge clk);
      check("clr count0 busy", {62'b0, busy, vec_valid}, 64'd0);
      tick();

      // Reset in the middle of a run
      load(64'h11); load(64'h22); load(64'h33);
      bad_mode = 2;
      pulse_start();
      tick();
      tick();
      check("pre-rst mismatch_cnt", {48'b0, mismatch_cnt}, 64'd1);
      check("pre-rst busy", {63'b0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst outputs", {busy, done, vec_valid, mismatch_seen}, 64'd0);
      check("midrst vec_out", vec_out, 64'd0);
      check("midrst mismatch_cnt", {48'b0, mismatch_cnt}, 64'd0);
      check("midrst first_bad_idx", {60'b0, first_bad_idx}, 64'd0);
      check("midrst load_ready", {63'b0, load_ready}, 64'd1);
      bad_mode = 0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("postrst c%0d done/busy", i), {62'b0, done, busy}, 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 Parameter VEC_W, default 64, width of one stimulus vector driven to the DUT.
REQ-002 Parameter OUT_W, default 32, width of each DUT result bus compared.
REQ-003 Parameter DEPTH, default 16, vector memory entries; power of two, at least 2.
REQ-004 Parameter HOLD, default 2, cycles each vector is held on vec_out; at least 1.
REQ-005 Clock is clk and reset is rst_n; one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 load_valid  input  1  load_data holds a vector to append to memory.
REQ-009 load_data  input  VEC_W  vector to append.
REQ-010 load_ready  output  1  vector memory accepts an append this cycle.
REQ-011 clr  input  1  empties the vector memory; honoured in IDLE only.
REQ-012 start  input  1  single-cycle request to run all stored vectors.
REQ-013 busy  output  1  high in APPLY.
REQ-014 done  output  1  one-cycle pulse at end of a run.
REQ-015 vec_out  output  VEC_W  stimulus to the DUT input ports.
REQ-016 vec_valid  output  1  vec_out carries a stored vector.
REQ-017 dut_y_a  input  OUT_W  result from the behavioural DUT.
REQ-018 dut_y_b  input  OUT_W  result from the synthesised DUT.
REQ-019 mismatch_cnt  output  16  number of vectors whose results differed.
REQ-020 first_bad_idx  output  clog2(DEPTH)  index of the first mismatching vector.
REQ-021 mismatch_seen  output  1  at least one mismatch occurred in the current or last run.

Function
REQ-022 FSM states are IDLE, APPLY and DONE; reset state is IDLE.
REQ-023 In IDLE, load_ready equals (count < DEPTH) and not start; in APPLY and DONE, load_ready is 0.
REQ-024 A load (load_valid and load_ready) writes mem[count] and increments count, which is count+1 wide.
REQ-025 In IDLE, clr sets count to 0; clr has priority over a simultaneous load; clr is ignored outside IDLE.
REQ-026 In IDLE, start with count > 0 moves to APPLY with idx=0 and hold=0, and clears mismatch_cnt, first_bad_idx and mismatch_seen.
REQ-027 In IDLE, start with count = 0 is ignored: no state change and no pulse on done.
REQ-028 start has priority over a simultaneous load; that load is not accepted.
REQ-029 start in APPLY or DONE is ignored.
REQ-030 In APPLY, vec_out = mem[idx] and vec_valid = 1, registered.
REQ-031 The first vector appears on the cycle after start is sampled.
REQ-032 Outside APPLY, vec_out = 0 and vec_valid = 0.
REQ-033 In APPLY, hold counts 0 to HOLD-1; the compare happens only on the cycle where hold = HOLD-1.
REQ-034 A compare with dut_y_a != dut_y_b increments mismatch_cnt, saturating at 16'hFFFF.
REQ-035 If mismatch_seen was 0 at that compare, it sets mismatch_seen and loads first_bad_idx with idx.
REQ-036 When hold = HOLD-1 and idx < count-1, idx increments and hold returns to 0.
REQ-037 When hold = HOLD-1 and idx = count-1, the FSM goes to DONE.
REQ-038 A run therefore occupies exactly count*HOLD cycles in APPLY.
REQ-039 DONE lasts one cycle with done = 1, then returns to IDLE; done is 0 in every other state.
REQ-040 Memory contents and count persist across runs, so a later start replays the same set of vectors.
REQ-041 busy = 1 exactly while in APPLY.

Reset
REQ-042 Asynchronous rst_n low forces IDLE, count=0, idx=0 and hold=0.
REQ-043 The same reset forces vec_out=0, vec_valid=0, done=0, mismatch_cnt=0, first_bad_idx=0 and mismatch_seen=0.
REQ-044 After reset, load_ready=1.
REQ-045 Reset during APPLY aborts the run and produces no done pulse.
REQ-046 Memory array contents need no reset.

Verification
REQ-047 Load 3 vectors 'h11, 'h22, 'h33, with dut_y_a = dut_y_b, then start -> vec_out shows 11,11,22,22,33,33 on cycles 1-6, done on cycle 7, mismatch_cnt=0.
REQ-048 Same 3 vectors, with dut_y_b = dut_y_a ^ 1 only while vec_out='h22 -> mismatch_cnt=1, first_bad_idx=1, mismatch_seen=1.
REQ-049 Load 16 vectors -> load_ready=0 afterwards, and a 17th load_valid does not change count; clr then gives load_ready=1 and count=0.
REQ-050 start with empty memory -> busy, done and vec_valid stay 0 for 10 cycles; start and load_valid together with count=2 -> run begins and count stays 2.
REQ-051 rst_n low at cycle 3 of a 3-vector run -> all outputs 0 immediately, no done, load_ready=1.
REQ-052 A second start after a run with mismatches, and results now matching -> mismatch_cnt, first_bad_idx and mismatch_seen all 0 at done, and the identical vector sequence is replayed.
